// File: rtl/ptn_gen_if.sv
// ptn_gen_if: sync/enable inputs and pixel outputs of the pattern generator
interface ptn_gen_if;
  logic       i_display_en;
  logic       i_hsync;
  logic       i_vsync;
  logic [2:0] i_ptn_sel;
  logic [3:0] o_vga_r;
  logic [3:0] o_vga_g;
  logic [3:0] o_vga_b;
  logic       o_vga_hsync;
  logic       o_vga_vsync;
  logic       o_vga_de;
  logic [7:0] o_frame_cnt;
  modport master (
    output i_display_en, i_hsync, i_vsync, i_ptn_sel,
    input  o_vga_r, o_vga_g, o_vga_b, o_vga_hsync, o_vga_vsync, o_vga_de, o_frame_cnt
  );
  modport slave (
    input  i_display_en, i_hsync, i_vsync, i_ptn_sel,
    output o_vga_r, o_vga_g, o_vga_b, o_vga_hsync, o_vga_vsync, o_vga_de, o_frame_cnt
  );
endinterface

// File: rtl/ptn_gen.sv
// ptn_gen: eight-pattern video generator with 2-cycle pixel-aligned sync/enable pipeline
module ptn_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BAR_W    = 80,
  parameter int CHK_LOG2 = 5
) (
  input logic       i_pck,
  input logic       i_rst_n,
  ptn_gen_if.slave  bus
);
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);
  localparam logic [6:0] BC_MAX = 7'(BAR_W - 1);
  logic [9:0]  r_xc, r_yc, r_x1, r_y1;
  logic [6:0]  r_bc;
  logic [2:0]  r_bar, r_bar1, r_mode;
  logic        r_de1, r_hs1, r_vs1, r_de2, r_hs2, r_vs2;
  logic [7:0]  r_fc;
  logic [11:0] r_rgb;
  logic        w_vs_fall, w_de_fall, w_grid, w_in_bar;
  logic [9:0]  w_pos;
  logic [11:0] w_rgb;
  // stage-1 enable/vsync double as the previous-value registers for edge detection
  assign w_vs_fall = r_vs1 & ~bus.i_vsync;
  assign w_de_fall = r_de1 & ~bus.i_display_en;
  assign w_pos     = {1'b0, r_fc, 1'b0};
  assign w_in_bar  = (r_x1 >= w_pos) && ({1'b0, r_x1} <= {1'b0, w_pos} + 11'd15);
  assign w_grid    = (r_x1 == 10'd0) || (r_x1 == X_LAST) || (r_y1 == 10'd0) || (r_y1 == Y_LAST) ||
                     (r_x1[5:0] == 6'd0) || (r_y1[5:0] == 6'd0);
  always_comb begin
    w_rgb = 12'h000;
    case (r_mode)
      3'd0: w_rgb = {{4{~r_bar1[1]}}, {4{~r_bar1[2]}}, {4{~r_bar1[0]}}};
      3'd1: w_rgb = {3{r_x1[7:4]}};
      3'd2: w_rgb = (r_x1[CHK_LOG2] ^ r_y1[CHK_LOG2]) ? 12'h000 : 12'hFFF;
      3'd3: w_rgb = w_grid ? 12'hFFF : 12'h004;
      3'd4: w_rgb = w_in_bar ? 12'hFFF : 12'h000;
      3'd5: w_rgb = 12'hF00;
      3'd6: w_rgb = 12'h0F0;
      default: w_rgb = 12'h00F;
    endcase
  end
  always_ff @(posedge i_pck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_xc   <= '0;
      r_yc   <= '0;
      r_bc   <= '0;
      r_bar  <= '0;
      r_x1   <= '0;
      r_y1   <= '0;
      r_bar1 <= '0;
      r_de1  <= 1'b0;
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_mode <= '0;
      r_fc   <= '0;
    end else begin
      r_de1  <= bus.i_display_en;
      r_hs1  <= bus.i_hsync;
      r_vs1  <= bus.i_vsync;
      r_x1   <= r_xc;
      r_y1   <= r_yc;
      r_bar1 <= r_bar;
      r_xc   <= bus.i_display_en ? r_xc + 10'd1 : 10'd0;
      r_bc   <= (!bus.i_display_en || r_bc == BC_MAX) ? 7'd0 : r_bc + 7'd1;
      r_bar  <= !bus.i_display_en ? 3'd0 : (r_bc == BC_MAX && r_bar != 3'd7) ? r_bar + 3'd1 : r_bar;
      r_yc   <= w_vs_fall ? 10'd0 : w_de_fall ? r_yc + 10'd1 : r_yc;
      if (w_vs_fall) begin
        r_mode <= bus.i_ptn_sel;
        r_fc   <= r_fc + 8'd1;
      end
    end
  end
  always_ff @(posedge i_pck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rgb <= '0;
      r_de2 <= 1'b0;
      r_hs2 <= 1'b1;
      r_vs2 <= 1'b1;
    end else begin
      r_rgb <= r_de1 ? w_rgb : 12'h000;
      r_de2 <= r_de1;
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
    end
  end
  assign {bus.o_vga_r, bus.o_vga_g, bus.o_vga_b} = r_rgb;
  assign bus.o_vga_de    = r_de2;
  assign bus.o_vga_hsync = r_hs2;
  assign bus.o_vga_vsync = r_vs2;
  assign bus.o_frame_cnt = r_fc;
endmodule

// File: tb/tb_ptn_gen.sv
// tb_ptn_gen: directed scenario tasks with hand-computed pixel values for ptn_gen
module tb_ptn_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_fc = 8'd0;
  logic [11:0] lrgb [0:639];
  logic        pre_de, first_de, post_de;
  logic [11:0] pre_rgb, post_rgb;
  ptn_gen_if bus ();
  ptn_gen dut (.i_pck(clk), .i_rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [11:0] cur_rgb();
    return {bus.o_vga_r, bus.o_vga_g, bus.o_vga_b};
  endfunction
  task automatic pix(input logic de, input logic hs, input logic vs);
    bus.i_display_en = de;
    bus.i_hsync = hs;
    bus.i_vsync = vs;
    @(posedge clk);
    #1;
  endtask
  task automatic vs_pulse();
    pix(0, 1, 1);
    pix(0, 1, 0);
    pix(0, 1, 1);
    pix(0, 1, 1);
    exp_fc = exp_fc + 8'd1;
  endtask
  // output seen after a pix() call belongs to the input of the previous call
  task automatic line(input int n, input bit cap);
    for (int x = 0; x < n; x++) begin
      pix(1, 1, 1);
      if (x == 0) begin
        pre_de = bus.o_vga_de;
        pre_rgb = cur_rgb();
      end else if (x == 1) first_de = bus.o_vga_de;
      if (cap && x > 0) lrgb[x-1] = cur_rgb();
    end
    pix(0, 1, 1);
    if (cap) lrgb[n-1] = cur_rgb();
    if (n == 1) first_de = bus.o_vga_de;
    pix(0, 0, 1);
    post_de = bus.o_vga_de;
    post_rgb = cur_rgb();
    pix(0, 0, 1);
    pix(0, 1, 1);
  endtask
  task automatic check_pixels(input string name, input int xs[], input logic [11:0] ex[]);
    foreach (xs[i]) begin
      total++;
      if (lrgb[xs[i]] !== ex[i]) begin
        bad++;
        $display("FAIL %s x=%0d got=%h exp=%h", name, xs[i], lrgb[xs[i]], ex[i]);
      end
    end
  endtask
  task automatic test_reset();
    bus.i_display_en = 0; bus.i_hsync = 1; bus.i_vsync = 1; bus.i_ptn_sel = 3'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    pix(0, 1, 1);
    pix(1, 0, 0);
    pix(1, 0, 0);
    pix(1, 0, 0);
    total++;
    if (bus.o_vga_de !== 1'b1 || bus.o_vga_hsync !== 1'b0 || bus.o_frame_cnt !== 8'd1) begin
      bad++;
      $display("FAIL pre_reset de=%b hs=%b fc=%0d exp de=1 hs=0 fc=1", bus.o_vga_de, bus.o_vga_hsync, bus.o_frame_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (cur_rgb() !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h exp=000", cur_rgb()); end
    total++;
    if (bus.o_vga_hsync !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%b exp=1", bus.o_vga_hsync); end
    total++;
    if (bus.o_vga_vsync !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%b exp=1", bus.o_vga_vsync); end
    total++;
    if (bus.o_vga_de !== 1'b0) begin bad++; $display("FAIL reset_de got=%b exp=0", bus.o_vga_de); end
    total++;
    if (bus.o_frame_cnt !== 8'd0) begin bad++; $display("FAIL reset_fc got=%0d exp=0", bus.o_frame_cnt); end
    bus.i_display_en = 0; bus.i_hsync = 1; bus.i_vsync = 1; bus.i_ptn_sel = 3'd3;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_fc = 8'd0;
    pix(0, 1, 1);
    pix(0, 1, 1);
    line(640, 1);
    check_pixels("first_frame_mode0", '{0, 80}, '{12'hFFF, 12'hFF0});
  endtask
  task automatic test_sync_align();
    bit hs_t [8] = '{1, 0, 0, 1, 1, 1, 1, 1};
    bit vs_t [8] = '{1, 1, 1, 1, 0, 0, 1, 1};
    for (int k = 0; k < 8; k++) begin
      pix(0, hs_t[k], vs_t[k]);
      if (k > 0) begin
        total++;
        if (bus.o_vga_hsync !== hs_t[k-1]) begin
          bad++; $display("FAIL sync_hs k=%0d got=%b exp=%b", k, bus.o_vga_hsync, hs_t[k-1]);
        end
        total++;
        if (bus.o_vga_vsync !== vs_t[k-1]) begin
          bad++; $display("FAIL sync_vs k=%0d got=%b exp=%b", k, bus.o_vga_vsync, vs_t[k-1]);
        end
      end
    end
    exp_fc = exp_fc + 8'd1;
  endtask
  task automatic test_color_bars();
    bus.i_ptn_sel = 3'd0;
    vs_pulse();
    line(640, 1);
    total++;
    if (pre_de !== 1'b0 || pre_rgb !== 12'h000) begin
      bad++; $display("FAIL de_early de=%b rgb=%h exp de=0 rgb=000", pre_de, pre_rgb);
    end
    total++;
    if (first_de !== 1'b1) begin bad++; $display("FAIL de_rise got=%b exp=1", first_de); end
    total++;
    if (post_de !== 1'b0) begin bad++; $display("FAIL de_fall got=%b exp=0", post_de); end
    check_pixels("bars", '{0, 79, 80, 160, 240, 400, 559, 560, 639},
                 '{12'hFFF, 12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF00, 12'h00F, 12'h000, 12'h000});
  endtask
  task automatic test_mode_latch();
    bus.i_ptn_sel = 3'd0;
    vs_pulse();
    line(640, 0);
    bus.i_ptn_sel = 3'd2;
    line(640, 1);
    check_pixels("latch_still_bars", '{32, 80}, '{12'hFFF, 12'hFF0});
    vs_pulse();
    line(640, 1);
    check_pixels("checker_y0", '{0, 32}, '{12'hFFF, 12'h000});
    for (int i = 0; i < 31; i++) line(1, 0);
    line(640, 1);
    check_pixels("checker_y32", '{0, 32}, '{12'h000, 12'hFFF});
  endtask
  task automatic test_frame_cnt();
    bus.i_ptn_sel = 3'd4;
    while (exp_fc != 8'd255) vs_pulse();
    total++;
    if (bus.o_frame_cnt !== 8'd255) begin bad++; $display("FAIL fc_255 got=%0d exp=255", bus.o_frame_cnt); end
    vs_pulse();
    total++;
    if (bus.o_frame_cnt !== 8'd0) begin bad++; $display("FAIL fc_wrap got=%0d exp=0", bus.o_frame_cnt); end
    while (exp_fc != 8'd10) vs_pulse();
    total++;
    if (bus.o_frame_cnt !== 8'd10) begin bad++; $display("FAIL fc_10 got=%0d exp=10", bus.o_frame_cnt); end
    line(640, 1);
    check_pixels("moving_bar", '{19, 20, 35, 36}, '{12'h000, 12'hFFF, 12'hFFF, 12'h000});
  endtask
  task automatic test_grid();
    bus.i_ptn_sel = 3'd3;
    vs_pulse();
    line(1, 0);
    line(640, 1);
    check_pixels("grid_y1", '{0, 1, 64}, '{12'hFFF, 12'h004, 12'hFFF});
    for (int y = 2; y < 100; y++) line(1, 0);
    line(640, 1);
    check_pixels("grid_y100", '{100, 639}, '{12'h004, 12'hFFF});
    for (int y = 101; y < 479; y++) line(1, 0);
    line(640, 1);
    check_pixels("grid_y479", '{1, 100}, '{12'hFFF, 12'hFFF});
  endtask
  task automatic test_solid();
    int n = 0;
    bus.i_ptn_sel = 3'd6;
    vs_pulse();
    line(640, 1);
    for (int x = 0; x < 640; x++) if (lrgb[x] !== 12'h0F0) n++;
    total++;
    if (n !== 0) begin bad++; $display("FAIL solid_green wrong_pixels=%0d exp=0 px0=%h", n, lrgb[0]); end
    total++;
    if (pre_rgb !== 12'h000 || post_rgb !== 12'h000) begin
      bad++; $display("FAIL solid_blank pre=%h post=%h exp=000", pre_rgb, post_rgb);
    end
  endtask
  initial begin
    test_reset();
    test_sync_align();
    test_color_bars();
    test_mode_latch();
    test_frame_cnt();
    test_grid();
    test_solid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
